// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: bundle between the execute stage and the iterative
// multiply/divide unit.
//
// Handshake: start is a level "valid" held by the pipeline until done; done
// is a one-cycle completion pulse that also acts as "ready" -- the
// operation is consumed in the cycle done is high, and stall_req is low in
// that same cycle so the pipeline advances with result. flush withdraws the
// request at any time.
//
// Signals:
//   start, op, opr1, opr2, flush   pipeline -> unit
//   stall_req, busy, done, result  unit -> pipeline
//   dbg_state                      unit -> observers (FSM state)
interface execute_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] opr1;
  logic [XLEN-1:0] opr2;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  modport master (
    output start, op, opr1, opr2, flush,
    input  stall_req, busy, done, result, dbg_state
  );

  modport slave (
    input  start, op, opr1, opr2, flush,
    output stall_req, busy, done, result, dbg_state
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M/RV64M multiply/divide unit for the execute
// stage. Multiplies by unsigned shift-add and divides by restoring division,
// both on operand magnitudes, retiring UNROLL bits per RUN cycle; a FIX cycle
// applies the result sign and selects high/low half or quotient/remainder.
// Divide-by-zero and signed overflow bypass RUN/FIX and finish in one cycle.
//
// Parameters: XLEN (32 or 64), UNROLL (1, 2 or 4, dividing XLEN).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   m (slave)  start/op/opr1/opr2/flush in; stall_req (comb), busy, done,
//              result (registered) out; dbg_state exposes the FSM state.
module execute_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  execute_muldiv_if.slave        m
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;        // multiplicand magnitude
  logic [XLEN-1:0]     b_q, b_d;        // divisor magnitude
  logic                neg_q, neg_d;    // negate final result in FIX
  logic [2*XLEN-1:0]   acc_q, acc_d;    // {hi, lo} product or {rem, quo}
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // ---------------------------------------------------------------------
  // Accept-time decode of the incoming operation
  // ---------------------------------------------------------------------
  logic            is_div;
  logic            sgn1, sgn2;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            res_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] most_neg;

  always_comb begin
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    is_div   = m.op[2];
    // opr1 is signed for MULH, MULHSU, DIV, REM; opr2 for MULH, DIV, REM.
    sgn1 = (m.op == 3'b001) || (m.op == 3'b010) ||
           (m.op == 3'b100) || (m.op == 3'b110);
    sgn2 = (m.op == 3'b001) || (m.op == 3'b100) || (m.op == 3'b110);
    neg1 = sgn1 && m.opr1[XLEN-1];
    neg2 = sgn2 && m.opr2[XLEN-1];
    mag1 = neg1 ? (~m.opr1 + 1'b1) : m.opr1;
    mag2 = neg2 ? (~m.opr2 + 1'b1) : m.opr2;
    // Remainder takes the dividend's sign; everything else the XOR.
    res_neg = (is_div && m.op[1]) ? neg1 : (neg1 ^ neg2);

    div_zero = is_div && (m.opr2 == '0);
    div_ovf  = is_div && !m.op[0] && (m.opr1 == most_neg) && (m.opr2 == '1);
    special  = div_zero || div_ovf;

    if (div_zero) special_res = m.op[1] ? m.opr1 : '1;
    else          special_res = m.op[1] ? '0     : m.opr1;
  end

  // ---------------------------------------------------------------------
  // One RUN cycle of the iterative core: UNROLL steps on acc_q
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;

  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    trial    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        // Restoring division: shift {rem, quo} left one bit and try to
        // subtract the divisor from the remainder.
        trial = step_acc[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (!trial[XLEN])
          step_acc = {trial[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
        else
          step_acc = {step_acc[2*XLEN-2:0], 1'b0};
      end else begin
        // Shift-add: the multiplier sits in the low half and is consumed
        // from bit 0; the carry of the add shifts into the high half.
        sum = {1'b0, step_acc[2*XLEN-1:XLEN]} +
              (step_acc[0] ? {1'b0, a_q} : '0);
        step_acc = {sum, step_acc[XLEN-1:1]};
      end
    end
  end

  // FIX-cycle result: sign correction and half / quotient-remainder select.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (op_q[2])
      fix_res = neg_q ? (~div_sel + 1'b1) : div_sel;
    else if (op_q[1:0] == 2'b00)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (m.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (m.start) state_d = special ? S_DONE : S_RUN;
        S_RUN:  if (cnt_q == CW'(1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs and datapath updates
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = (state_d == S_RUN) || (state_d == S_FIX);
    done_d   = (state_d == S_DONE);

    if (m.flush) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m.start) begin
            op_d  = m.op;
            a_d   = mag1;
            b_d   = mag2;
            neg_d = res_neg;
            // Multiplier or dividend starts in the low half.
            acc_d = {{XLEN{1'b0}}, is_div ? mag1 : mag2};
            if (special) begin
              cnt_d    = '0;
              result_d = special_res;
            end else begin
              cnt_d = CW'(N);
            end
          end
        end
        S_RUN: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
        end
        S_FIX: begin
          result_d = fix_res;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The request drops in the DONE cycle so the pipeline takes result.
  assign m.stall_req = m.start & ~done_q & ~m.flush;
  assign m.busy      = busy_q;
  assign m.done      = done_q;
  assign m.result    = result_q;
  assign m.dbg_state = state_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: randomized and directed checks of execute_muldiv in
// three configurations (32/1, 32/4, 64/4) against a plain-arithmetic model.
module tb_execute_muldiv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUTs ----------------
  execute_muldiv_if #(.XLEN(32)) if0 ();
  execute_muldiv_if #(.XLEN(32)) if1 ();
  execute_muldiv_if #(.XLEN(64)) if2 ();

  execute_muldiv #(.XLEN(32), .UNROLL(1)) u0 (.clk(clk), .rst(rst), .m(if0.slave));
  execute_muldiv #(.XLEN(32), .UNROLL(4)) u1 (.clk(clk), .rst(rst), .m(if1.slave));
  execute_muldiv #(.XLEN(64), .UNROLL(4)) u2 (.clk(clk), .rst(rst), .m(if2.slave));

  int          sel;
  logic        start_v, flush_v;
  logic [2:0]  op_v;
  logic [63:0] a_v, b_v;

  assign if0.start = start_v && (sel == 0);
  assign if1.start = start_v && (sel == 1);
  assign if2.start = start_v && (sel == 2);
  assign if0.op = op_v;  assign if1.op = op_v;  assign if2.op = op_v;
  assign if0.opr1 = a_v[31:0]; assign if0.opr2 = b_v[31:0];
  assign if1.opr1 = a_v[31:0]; assign if1.opr2 = b_v[31:0];
  assign if2.opr1 = a_v;       assign if2.opr2 = b_v;
  assign if0.flush = flush_v; assign if1.flush = flush_v; assign if2.flush = flush_v;

  // ---------------- scoreboard ----------------
  int          n_err = 0;
  int          n_chk = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (32-bit) ----------------
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'b000: begin p = ua * ub;              return p[31:0];  end
      3'b001: begin p = sa * sb;              return p[63:32]; end
      3'b010: begin p = sa * longint'(ub);    return p[63:32]; end
      3'b011: begin p = ua * ub;              return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit fast32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic sample(input int unit, output logic d, output logic s, output logic bz,
                        output logic [63:0] r);
    case (unit)
      0: begin d = if0.done; s = if0.stall_req; bz = if0.busy; r = {32'b0, if0.result}; end
      1: begin d = if1.done; s = if1.stall_req; bz = if1.busy; r = {32'b0, if1.result}; end
      default: begin d = if2.done; s = if2.stall_req; bz = if2.busy; r = if2.result; end
    endcase
  endtask

  // Called just after a rising edge; that cycle is the accept cycle (cycle 0).
  // Returns just after the rising edge that starts the cycle following DONE.
  task automatic run_op(input int unit, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input string tag);
    int          lat, busy_cnt;
    bit          stall_ok, got_done;
    logic        d, s, bz;
    logic [63:0] r, e;
    sel = unit; op_v = op; a_v = a; b_v = b; start_v = 1'b1;
    exp_q.push_back(exp);
    lat = 0; busy_cnt = 0; stall_ok = 1'b1; got_done = 1'b0;
    d = 1'b0; s = 1'b0; bz = 1'b0; r = '0;
    while (!got_done && lat <= 200) begin
      @(negedge clk);
      sample(unit, d, s, bz, r);
      if (d) got_done = 1'b1;
      else begin
        if (!s) stall_ok = 1'b0;
        if (bz) busy_cnt++;
        lat++;
      end
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    if (got_done) begin
      check({tag, "_result"},      r,                  e);
      check({tag, "_latency"},     64'(lat),           64'(exp_lat));
      check({tag, "_stall_done"},  64'(s),             64'd0);
      check({tag, "_busy_done"},   64'(bz),            64'd0);
      check({tag, "_stall_hold"},  64'(stall_ok),      64'd1);
      check({tag, "_busy_cycles"}, 64'(busy_cnt),      64'(exp_lat - 1));
      last_res = e;
    end
    @(posedge clk); #1;
    start_v = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  r_op;
    logic [31:0] ra, rb;
    int          done_seen;

    sel = 0; start_v = 1'b0; flush_v = 1'b0; op_v = '0; a_v = '0; b_v = '0;
    last_res = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0",   64'(if0.busy),      64'd0);
    check("rst_done0",   64'(if0.done),      64'd0);
    check("rst_result0", 64'(if0.result),    64'd0);
    check("rst_stall0",  64'(if0.stall_req), 64'd0);
    check("rst_result2", if2.result,         64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Multiply, XLEN=32 UNROLL=1
    run_op(0, 3'b000, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, 34, "mul_7");
    run_op(0, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 34, "mulh_min");
    run_op(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 34, "mulhu_max");
    run_op(0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 34, "mulhsu_m1");
    // Divide / remainder, back-to-back with one IDLE cycle between
    run_op(0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 34, "div_m7");
    run_op(0, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34, "rem_m7");
    run_op(0, 3'b101, 64'd100,       64'd7, 64'd14,        34, "divu_100");
    run_op(0, 3'b111, 64'd100,       64'd7, 64'd2,         34, "remu_100");
    // Special cases (fast path)
    run_op(0, 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF, 1, "div_by0");
    run_op(0, 3'b110, 64'd5, 64'd0, 64'd5,         1, "rem_by0");
    run_op(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div_ovf");
    run_op(0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0,         1, "rem_ovf");

    // Flush in cycle 10 of a DIVU; new MUL accepted in cycle 11
    sel = 0; op_v = 3'b101; a_v = 64'd1000; b_v = 64'd3; start_v = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush_v = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(if0.stall_req), 64'd0);
    check("flush_done10", 64'(if0.done), 64'd0);
    @(posedge clk); #1;
    flush_v = 1'b0;
    check("flush_done11", 64'(if0.done), 64'd0);
    check("flush_busy11", 64'(if0.busy), 64'd0);
    check("flush_result", 64'(if0.result), last_res);
    run_op(0, 3'b000, 64'd1234, 64'd5678, 64'd7006652, 34, "mul_after_flush");

    // Asynchronous reset in cycle 5 of a MUL
    sel = 0; op_v = 3'b000; a_v = 64'd3; b_v = 64'd9; start_v = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_busy",   64'(if0.busy),   64'd0);
    check("arst_done",   64'(if0.done),   64'd0);
    check("arst_result", 64'(if0.result), 64'd0);
    start_v = 1'b0;
    @(negedge clk) rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (if0.done) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);
    @(posedge clk); #1;
    run_op(0, 3'b011, 64'h0001_0000, 64'h0001_0000, 64'd1, 34, "mulhu_after_rst");

    // Randomized, UNROLL=1
    for (int i = 0; i < 150; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra = pick(); rb = pick();
      run_op(0, r_op, {32'b0, ra}, {32'b0, rb}, {32'b0, ref32(r_op, ra, rb)},
             fast32(r_op, ra, rb) ? 1 : 34, "rand_u1");
    end

    // UNROLL=4, XLEN=32
    run_op(1, 3'b000, 64'h1234_5678, 64'h10, 64'h2345_6780, 10, "u4_mul");
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra = pick(); rb = pick();
      run_op(1, r_op, {32'b0, ra}, {32'b0, rb}, {32'b0, ref32(r_op, ra, rb)},
             fast32(r_op, ra, rb) ? 1 : 10, "rand_u4");
    end

    // UNROLL=4, XLEN=64
    run_op(2, 3'b101, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 18, "x64_divu");
    run_op(2, 3'b111, 64'h8000_0000_0000_0000, 64'd3, 64'd2, 18, "x64_remu");
    run_op(2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 18, "x64_mul");
    run_op(2, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 18, "x64_mulh");
    run_op(2, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, "x64_div_ovf");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M/RV64M multiply–divide unit inside the execute stage, beside the single-cycle ALU. It takes already-forwarded operands and an M-extension funct3 code, then computes the result over several cycles. While it computes, it holds `stall_req` high so the pipeline freezes. Operand width and the number of bits retired per cycle are parameters; signed and unsigned operations, divide-by-zero and signed overflow follow the RISC-V M rules.

## Interface
- `XLEN`, 32: operand and result width. Must be 32 or 64.
- `UNROLL`, 1: bits processed per RUN cycle. Must be 1, 2 or 4, and must divide `XLEN`. Define N = `XLEN`/`UNROLL`.
- `clk`  in  1  clock. Everything is rising-edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  a valid M-op sits in execute. Held high until `done`.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opr1`  in  XLEN  forwarded rs1 (multiplicand / dividend).
- `opr2`  in  XLEN  forwarded rs2 (multiplier / divisor).
- `flush`  in  1  pipeline flush of execute. Aborts any operation.
- `stall_req`  out  1  combinational stall request to the pipeline controller.
- `busy`  out  1  registered. High in RUN and FIX.
- `done`  out  1  registered one-cycle pulse. `result` is valid while it is high.
- `result`  out  XLEN  registered result. Holds its value until the next `done`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterative core.
  - FIX: sign correction and selection of the high/low product half or quotient/remainder.
  - DONE: one cycle, `done` = 1.
- Accept: in IDLE, with `start`=1 and `flush`=0, capture `op` and the absolute values of the operands. Also capture the result sign and the special-case flags. Operand changes after accept are ignored.
- Transitions:
  - IDLE→RUN on accept.
  - IDLE→DONE on accept of a special case (fast path).
  - RUN→FIX after N iterations, counted by a down-counter loaded with N.
  - FIX→DONE.
  - DONE→IDLE unconditionally.
- Multiply: unsigned shift-add on magnitudes into a 2·XLEN product.
  - Operand signedness: MULH treats both as signed. MULHSU treats `opr1` as signed and `opr2` as unsigned. MULHU and MUL treat both as unsigned; MUL's low half is sign-agnostic.
  - FIX negates the 2·XLEN product when the sign flag is set.
  - MUL returns bits [XLEN-1:0]; the others return [2·XLEN-1:XLEN].
- Divide: restoring division on magnitudes.
  - Signed quotient sign = sign(`opr1`) XOR sign(`opr2`).
  - Signed remainder sign = sign(`opr1`).
  - Unsigned ops never negate.
- Special cases (fast path, no RUN):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return `opr1`.
  - Signed overflow, DIV of the most negative value by −1: DIV returns `opr1`; REM returns 0.
- `stall_req` = `start` & ~`done` & ~`flush`.
- Flush, any state: next state is IDLE. The counter clears, `done` stays 0 next cycle, and `result` is unchanged. Flush has priority over accept.
- Back-to-back ops: a new accept is legal in the first IDLE cycle after DONE.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `result`=0, counter=0, all internal operand registers 0.
  - `stall_req` follows its equation.
  - Reset mid-operation discards the operation; no `done` follows.
- Cycle 0 is the accept cycle (IDLE, `start`=1).
  - Normal path: RUN in cycles 1..N, FIX in cycle N+1, DONE in cycle N+2. Latency is N+2.
  - Fast path: DONE in cycle 1.
- `stall_req` is high from cycle 0 through the cycle before DONE. It is low in the DONE cycle, so the pipeline advances with `result`.
- `busy` is high in cycles 1..N+1 and low in IDLE/DONE.
- In the DONE cycle, `op` is never re-sampled. The same instruction still presenting `start`=1 is not re-accepted.
- `start` dropping mid-operation, without a flush, is illegal. The operation completes regardless.

## Test plan
- Multiply, `XLEN`=32, `UNROLL`=1:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - `done` exactly in cycle 34; `stall_req` high in cycles 0–33, low in 34; `busy` high in cycles 1–33.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Back-to-back with no gap except the single IDLE cycle.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with `done` in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both with `done` in cycle 1.
- Abort:
  - `flush` in cycle 10 of a DIVU → IDLE in cycle 11, no `done`, `result` unchanged; a new MUL accepted in cycle 11 completes correctly.
  - `rst` low in cycle 5 → `busy`/`done`/`result` 0 immediately, before the next edge.
- `UNROLL`=4, `XLEN`=32:
  - MUL 0x12345678×0x10 → 0x23456780 with `done` in cycle 10.
  - `XLEN`=64: DIVU 2^63/3 → 0x2AAAAAAAAAAAAAAA.
